// File: rtl/calc_stream_controller.sv
// Streams word pairs from memory through an external adder and packs the sums into write words.
// Optional build macro CALC_CTRL_SATURATE_EN: saturate a slot to all-ones when the adder carries out.
module calc_stream_controller #(
  parameter int ADDR_W           = 10,
  parameter int DATA_W           = 32,
  parameter int MEM_WORD_SIZE    = 64,
  parameter int RESULTS_PER_WORD = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        read_start_addr,
  input  logic [ADDR_W-1:0]        read_end_addr,
  input  logic [ADDR_W-1:0]        write_start_addr,
  input  logic [ADDR_W-1:0]        write_end_addr,
  output logic                     read,
  output logic [ADDR_W-1:0]        r_addr,
  input  logic [MEM_WORD_SIZE-1:0] r_data,
  output logic                     write,
  output logic [ADDR_W-1:0]        w_addr,
  output logic [MEM_WORD_SIZE-1:0] w_data,
  output logic [DATA_W-1:0]        op_a,
  output logic [DATA_W-1:0]        op_b,
  input  logic [DATA_W-1:0]        sum_i,
  input  logic                     carry_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam int SLOT_W = $clog2(RESULTS_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE, ST_READ, ST_WAIT, ST_ADD, ST_WRITE, ST_FLUSH, ST_DONE
  } state_t;

  state_t                   state, state_nx;
  logic [ADDR_W-1:0]        rd_ptr, wr_ptr, rd_end, wr_end;
  logic                     rd_past, wr_past;
  logic [SLOT_W-1:0]        slot;
  logic [MEM_WORD_SIZE-1:0] pack;
  logic [DATA_W-1:0]        slot_val;
  logic                     rd_over, wr_over, last_slot;

  // The *_past flags remember a pointer wrapping past the top of memory, so a
  // wrapped pointer is never mistaken for one still inside its range.
  assign rd_over   = rd_past || (rd_ptr > rd_end);
  assign wr_over   = wr_past || (wr_ptr > wr_end);
  assign last_slot = (slot == SLOT_W'(RESULTS_PER_WORD - 1));

`ifdef CALC_CTRL_SATURATE_EN
  assign slot_val = carry_i ? {DATA_W{1'b1}} : sum_i;
`else
  logic unused_carry;
  assign unused_carry = carry_i;
  assign slot_val     = sum_i;
`endif

  if (MEM_WORD_SIZE > 2 * DATA_W) begin : g_spare_bits
    logic unused_hi;
    assign unused_hi = ^r_data[MEM_WORD_SIZE-1:2*DATA_W];
  end

  assign w_data = pack;
  assign busy_o = (state != ST_IDLE) && (state != ST_DONE);
  assign done_o = (state == ST_DONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    read     = 1'b0;
    write    = 1'b0;
    r_addr   = '0;
    w_addr   = '0;
    case (state)
      ST_IDLE, ST_DONE: if (start_i) state_nx = ST_READ;
      ST_READ: begin
        if (rd_over) begin
          state_nx = (slot != '0) ? ST_FLUSH : ST_DONE;
        end else begin
          read     = 1'b1;
          r_addr   = rd_ptr;
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: state_nx = ST_ADD;
      ST_ADD:  state_nx = last_slot ? ST_WRITE : ST_READ;
      ST_WRITE: begin
        if (wr_over) begin
          state_nx = ST_DONE;
        end else begin
          write    = 1'b1;
          w_addr   = wr_ptr;
          state_nx = ST_READ;
        end
      end
      ST_FLUSH: begin
        if (!wr_over) begin
          write  = 1'b1;
          w_addr = wr_ptr;
        end
        state_nx = ST_DONE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      rd_end  <= '0;
      wr_end  <= '0;
      rd_past <= 1'b0;
      wr_past <= 1'b0;
      slot    <= '0;
      pack    <= '0;
      op_a    <= '0;
      op_b    <= '0;
      err_o   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            rd_ptr  <= read_start_addr;
            wr_ptr  <= write_start_addr;
            rd_end  <= read_end_addr;
            wr_end  <= write_end_addr;
            rd_past <= 1'b0;
            wr_past <= 1'b0;
            slot    <= '0;
            pack    <= '0;
            err_o   <= 1'b0;
          end
        end
        ST_WAIT: begin
          op_a <= r_data[DATA_W-1:0];
          op_b <= r_data[2*DATA_W-1:DATA_W];
        end
        ST_ADD: begin
          pack[int'(slot)*DATA_W +: DATA_W] <= slot_val;
          if (!last_slot) begin
            slot   <= slot + SLOT_W'(1);
            rd_ptr <= rd_ptr + ADDR_W'(1);
            if (&rd_ptr) rd_past <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (wr_over) begin
            err_o <= 1'b1;
          end else begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            if (&wr_ptr) wr_past <= 1'b1;
            rd_ptr <= rd_ptr + ADDR_W'(1);
            if (&rd_ptr) rd_past <= 1'b1;
            slot   <= '0;
            pack   <= '0;
          end
        end
        ST_FLUSH: begin
          if (wr_over) err_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
